dice_roll_sequencer: RTL and testbench
======================================

DICE_ROLL_SEQUENCER -- requirements
Module: dice_roll_sequencer

Interface
REQ-001 SHALL have parameter TUMBLE_CYCLES, default 16: cycles of tumble animation before the first face request (legal range 1..255).
REQ-002 SHALL have parameter MAX_DICE, default 4: the largest number of dice summed in one roll.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port roll_start, input, 1 bit: a single-cycle roll request.
REQ-006 SHALL have port dice_type, input, 3 bits: the die selection, with the same encoding as the dice roller (d4, d6, d8, d10, d12, d20, other).
REQ-007 SHALL have port dice_count, input, 2 bits: the number of dice minus 1.
REQ-008 SHALL have port modifier, input, 5 bits: an unsigned value added once per roll.
REQ-009 SHALL have port adv_mode, input, 2 bits: 00 normal, 01 advantage, 10 disadvantage, 11 normal.
REQ-010 SHALL have port face_req, output, 1 bit: a request to the LFSR die datapath for one face value.
REQ-011 SHALL have port face_sides, output, 5 bits: the side count of the requested die (4/6/8/10/12/20, or 1 for other).
REQ-012 SHALL have port face_ack, input, 1 bit: the datapath's acknowledge; face_value is valid on this cycle.
REQ-013 SHALL have port face_value, input, 5 bits: the face value, guaranteed by the datapath to lie in 1..face_sides.
REQ-014 SHALL have port tumble, output, 1 bit: high during the animation phase, used by the display to blank or spin.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port total, output, 7 bits: the last completed result, held until the next completion.
REQ-017 SHALL have port total_valid, output, 1 bit: a one-cycle pulse when total updates.

Function
REQ-018 SHALL use the states IDLE, TUMBLE, REQ, ACC, DONE.
REQ-019 IDLE->TUMBLE SHALL occur on roll_start=1; on that edge dice_type, dice_count, modifier and adv_mode are latched, and later input changes have no effect on the roll.
REQ-020 roll_start while busy SHALL be ignored and SHALL NOT be queued.
REQ-021 TUMBLE SHALL last exactly TUMBLE_CYCLES cycles, then move to REQ; tumble=1 exactly in TUMBLE.
REQ-022 In REQ, face_req SHALL be 1 and held until the cycle face_ack=1; on that edge face_value is captured, face_req drops, and the state moves to ACC.
REQ-023 face_ack while face_req=0 SHALL be ignored.
REQ-024 ACC SHALL last one cycle and add the face to the sum.
REQ-025 After ACC, the block SHALL return to REQ if more faces are outstanding, otherwise go to DONE.
REQ-026 The number of faces requested SHALL be (dice_count+1), doubled when advantage or disadvantage is active.
REQ-027 In advantage/disadvantage mode, faces SHALL be taken in pairs, and the larger (advantage) or smaller (disadvantage) face of each pair is summed.
REQ-028 DONE SHALL last one cycle: total = sum + modifier, total_valid=1, then IDLE.
REQ-029 Arithmetic SHALL be unsigned and 7-bit; the maximum 4*20+31=111 is exact, with no saturation needed.
REQ-030 Minimum latency from roll_start to total_valid, with ack on the same cycle as the request, SHALL be TUMBLE_CYCLES + 2*faces + 1 cycles.

Reset
REQ-031 With reset=0 at a clock edge, the block SHALL go to IDLE, with face_req=0, tumble=0, busy=0, total=0, total_valid=0, the accumulator cleared and latched configuration cleared.
REQ-032 Reset mid-roll SHALL abandon the roll with no total_valid pulse; face_req drops on the same edge.

Configuration
REQ-033 Macro DICE_SEQ_ADVANTAGE_EN defined: adv_mode behaves as in REQ-026 and REQ-027.
REQ-034 Macro DICE_SEQ_ADVANTAGE_EN undefined: the adv_mode port remains but is ignored (always treated as normal), and the pair-compare logic is not synthesized.

Structure
REQ-035 A shared package dice_pkg SHALL hold the dice_type encodings, the sides lookup constants, the state enum and the total width (7).
REQ-036 One sub-module, dice_tumble_timer, SHALL implement the TUMBLE_CYCLES down-counter with start/expire; all other logic stays in dice_roll_sequencer.

Verification
REQ-037 Scenario: reset, then TUMBLE_CYCLES=4, roll_start with d6, count=0 (one die), mod=3, ack one cycle after the request with value 5 -> tumble high for 4 cycles, total=8, exactly one total_valid pulse.
REQ-038 Scenario: d20, count=3 (four dice), mod=31, faces 20,20,20,20 -> total=111, with no wrap.
REQ-039 Scenario (macro on): d20 advantage, count=0, faces 7 then 15 -> total=15; disadvantage with the same faces -> total=7.
REQ-040 Scenario: roll_start pulsed again during TUMBLE and REQ, and dice_type changed mid-roll -> one result only, computed from the latched configuration.
REQ-041 Scenario: ack held off 10 cycles, with spurious face_ack before the request -> face_req stays high throughout and the spurious ack is ignored.
REQ-042 Scenario: reset asserted during the second REQ of a 3-die roll -> next cycle is IDLE with face_req=0 and total=0, and no total_valid pulse occurs.

Source files
------------

// File: rtl/dice_pkg.sv
// dice_pkg: shared dice encodings, sides lookup, sequencer states and result width
package dice_pkg;
  localparam int TOTAL_W = 7;
  localparam logic [2:0] DT_D4 = 3'd0, DT_D6 = 3'd1, DT_D8 = 3'd2, DT_D10 = 3'd3, DT_D12 = 3'd4, DT_D20 = 3'd5;
  localparam logic [4:0] SIDES_D4 = 5'd4, SIDES_D6 = 5'd6, SIDES_D8 = 5'd8, SIDES_D10 = 5'd10;
  localparam logic [4:0] SIDES_D12 = 5'd12, SIDES_D20 = 5'd20, SIDES_OTHER = 5'd1;
  typedef enum logic [2:0] {IDLE, TUMBLE, REQ, ACC, DONE} state_e;
  function automatic logic [4:0] sides_of(input logic [2:0] t);
    return t == DT_D4 ? SIDES_D4 : t == DT_D6 ? SIDES_D6 : t == DT_D8 ? SIDES_D8 :
           t == DT_D10 ? SIDES_D10 : t == DT_D12 ? SIDES_D12 : t == DT_D20 ? SIDES_D20 : SIDES_OTHER;
  endfunction
endpackage

// File: rtl/dice_tumble_timer.sv
// dice_tumble_timer: runs CYCLES cycles after start and flags the last one with expire
module dice_tumble_timer #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic expire
);
  logic [7:0] cnt;
  logic active;
  assign expire = active && cnt == 8'd0;
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt <= 8'(CYCLES - 1);
      active <= 1'b1;
    end else if (expire) active <= 1'b0;
    else if (active) cnt <= cnt - 8'd1;
endmodule

// File: rtl/dice_roll_sequencer.sv
// dice_roll_sequencer: tumbles, requests faces and sums them plus a modifier; DICE_SEQ_ADVANTAGE_EN adds advantage/disadvantage pairs
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int TUMBLE_CYCLES = 16,
  parameter int MAX_DICE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               roll_start,
  input  logic [2:0]         dice_type,
  input  logic [1:0]         dice_count,
  input  logic [4:0]         modifier,
  input  logic [1:0]         adv_mode,
  output logic               face_req,
  output logic [4:0]         face_sides,
  input  logic               face_ack,
  input  logic [4:0]         face_value,
  output logic               tumble,
  output logic               busy,
  output logic [TOTAL_W-1:0] total,
  output logic               total_valid
);
  localparam logic [2:0] MAX_N = 3'(MAX_DICE);
  state_e state, state_n;
  logic [2:0] type_r, n_dice, n_sel;
  logic [4:0] mod_r, face_r, add_val;
  logic [3:0] left, faces;
  logic [TOTAL_W-1:0] sum, sum_n;
  logic start, expire, adv_in, add_en;
  assign start = state == IDLE && roll_start;
  assign n_dice = {1'b0, dice_count} + 3'd1;
  assign n_sel = n_dice > MAX_N ? MAX_N : n_dice;
  assign faces = adv_in ? {n_sel, 1'b0} : {1'b0, n_sel};
  assign sum_n = add_en ? sum + TOTAL_W'(add_val) : sum;
  assign face_req = state == REQ;
  assign tumble = state == TUMBLE;
  assign busy = state != IDLE;
  assign total_valid = state == DONE;
  assign face_sides = sides_of(type_r);
  dice_tumble_timer #(.CYCLES(TUMBLE_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .start(start),
    .expire(expire)
  );
  always_comb
    state_n = state == IDLE   ? (roll_start ? TUMBLE : IDLE) :
              state == TUMBLE ? (expire ? REQ : TUMBLE) :
              state == REQ    ? (face_ack ? ACC : REQ) :
              state == ACC    ? (left == 4'd1 ? DONE : REQ) : IDLE;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      type_r <= '0;
      mod_r <= '0;
      left <= '0;
      sum <= '0;
      face_r <= '0;
      total <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        type_r <= dice_type;
        mod_r <= modifier;
        left <= faces;
        sum <= '0;
      end
      if (state == REQ && face_ack) face_r <= face_value;
      if (state == ACC) begin
        left <= left - 4'd1;
        sum <= sum_n;
        if (left == 4'd1) total <= sum_n + TOTAL_W'(mod_r);
      end
    end
`ifdef DICE_SEQ_ADVANTAGE_EN
  // first face of each pair is parked in pair_r; the second one decides what is summed
  logic adv_r, dis_r, half;
  logic [4:0] pair_r, best;
  assign adv_in = ^adv_mode;
  assign best = dis_r ? (face_r < pair_r ? face_r : pair_r) : (face_r > pair_r ? face_r : pair_r);
  assign add_en = !adv_r || half;
  assign add_val = adv_r ? best : face_r;
  always_ff @(posedge clk)
    if (!reset) begin
      adv_r <= 1'b0;
      dis_r <= 1'b0;
      half <= 1'b0;
      pair_r <= '0;
    end else if (start) begin
      adv_r <= adv_in;
      dis_r <= adv_mode == 2'b10;
      half <= 1'b0;
    end else if (state == ACC && adv_r) begin
      half <= !half;
      pair_r <= face_r;
    end
`else
  logic unused_adv;
  assign unused_adv = ^adv_mode;
  assign adv_in = 1'b0;
  assign add_en = 1'b1;
  assign add_val = face_r;
`endif
endmodule

// File: tb/tb_dice_roll_sequencer.sv
// tb_dice_roll_sequencer: directed rolls with hand-computed totals, TUMBLE_CYCLES=4
module tb_dice_roll_sequencer;
  logic clk = 1'b0, reset = 1'b0, roll_start = 1'b0, face_ack = 1'b0;
  logic [2:0] dice_type = '0;
  logic [1:0] dice_count = '0, adv_mode = '0;
  logic [4:0] modifier = '0, face_value = '0, face_sides;
  logic face_req, tumble, busy, total_valid;
  logic [6:0] total;
  int nchk = 0, nfail = 0, pulses = 0, cyc = 0;
  int fv[8];
  dice_roll_sequencer #(.TUMBLE_CYCLES(4), .MAX_DICE(4)) dut (
    .clk(clk), .reset(reset), .roll_start(roll_start), .dice_type(dice_type),
    .dice_count(dice_count), .modifier(modifier), .adv_mode(adv_mode),
    .face_req(face_req), .face_sides(face_sides), .face_ack(face_ack),
    .face_value(face_value), .tumble(tumble), .busy(busy), .total(total),
    .total_valid(total_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (total_valid) pulses++;
  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_roll(input string tag, input logic [2:0] t, input logic [1:0] c, input logic [4:0] m,
                         input logic [1:0] a, input int nf, input int dly, input int exp_total,
                         input int exp_sides, input bit disturb);
    int tcnt, served, w, p0, c0;
    bit held, sides_ok;
    p0 = pulses;
    held = 1'b1;
    sides_ok = 1'b1;
    @(negedge clk);
    dice_type = t; dice_count = c; modifier = m; adv_mode = a; roll_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    roll_start = 1'b0;
    tcnt = 0;
    while (tumble && tcnt < 300) begin
      if (disturb) begin
        roll_start = tcnt == 1;
        face_ack = tcnt == 0;
        face_value = 5'd31;
        dice_type = 3'd7;
        modifier = 5'd0;
        dice_count = 2'd3;
      end
      tcnt++;
      @(negedge clk);
    end
    roll_start = 1'b0;
    face_ack = 1'b0;
    chk({tag, " tumble_cycles"}, tcnt, 4);
    served = 0;
    while (served < nf) begin
      w = 0;
      while (!face_req && w < 50) begin w++; @(negedge clk); end
      if (!face_req) begin
        chk({tag, " face_req_timeout"}, 0, 1);
        break;
      end
      if (face_sides != 5'(exp_sides)) sides_ok = 1'b0;
      for (int d = 0; d < dly; d++) begin
        roll_start = disturb;
        @(negedge clk);
        roll_start = 1'b0;
        held &= face_req;
      end
      face_ack = 1'b1;
      face_value = 5'(fv[served]);
      @(negedge clk);
      face_ack = 1'b0;
      served++;
    end
    chk({tag, " sides_latched"}, int'(sides_ok), 1);
    chk({tag, " face_req_held"}, int'(held), 1);
    w = 0;
    while (!total_valid && w < 50) begin w++; @(negedge clk); end
    chk({tag, " total_valid"}, int'(total_valid), 1);
    chk({tag, " total"}, int'(total), exp_total);
    chk({tag, " latency"}, cyc - c0, 4 + 2 * nf + 1 + nf * dly);
    repeat (3) @(negedge clk);
    chk({tag, " one_pulse"}, pulses - p0, 1);
    chk({tag, " idle_after"}, int'(busy), 0);
    chk({tag, " total_held"}, int'(total), exp_total);
  endtask
  initial begin
    int w, p0;
    repeat (2) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst face_req", int'(face_req), 0);
    chk("rst tumble", int'(tumble), 0);
    chk("rst total", int'(total), 0);
    chk("rst total_valid", int'(total_valid), 0);
    reset = 1'b1;
    fv[0] = 5;
    do_roll("d6_one", 3'd1, 2'd0, 5'd3, 2'b00, 1, 1, 8, 6, 1'b0);
    fv[0] = 3; fv[1] = 4;
    do_roll("d4_two_min", 3'd0, 2'd1, 5'd0, 2'b00, 2, 0, 7, 4, 1'b0);
    fv[0] = 20; fv[1] = 20; fv[2] = 20; fv[3] = 20;
    do_roll("d20_max", 3'd5, 2'd3, 5'd31, 2'b00, 4, 0, 111, 20, 1'b0);
    fv[0] = 1;
    do_roll("other", 3'd6, 2'd0, 5'd0, 2'b00, 1, 0, 1, 1, 1'b0);
`ifdef DICE_SEQ_ADVANTAGE_EN
    fv[0] = 7; fv[1] = 15;
    do_roll("adv", 3'd5, 2'd0, 5'd0, 2'b01, 2, 0, 15, 20, 1'b0);
    do_roll("disadv", 3'd5, 2'd0, 5'd0, 2'b10, 2, 0, 7, 20, 1'b0);
    fv[0] = 9;
    do_roll("mode11", 3'd5, 2'd0, 5'd0, 2'b11, 1, 0, 9, 20, 1'b0);
    fv[0] = 3; fv[1] = 9; fv[2] = 12; fv[3] = 2;
    do_roll("adv_two", 3'd4, 2'd1, 5'd1, 2'b01, 4, 0, 22, 12, 1'b0);
    do_roll("disadv_two", 3'd4, 2'd1, 5'd1, 2'b10, 4, 0, 6, 12, 1'b0);
`else
    fv[0] = 7;
    do_roll("adv_ignored", 3'd5, 2'd0, 5'd0, 2'b01, 1, 0, 7, 20, 1'b0);
`endif
    fv[0] = 8; fv[1] = 1;
    do_roll("disturbed", 3'd2, 2'd1, 5'd2, 2'b00, 2, 10, 11, 8, 1'b1);
    p0 = pulses;
    @(negedge clk);
    dice_type = 3'd3; dice_count = 2'd2; modifier = 5'd5; adv_mode = 2'b00; roll_start = 1'b1;
    @(negedge clk);
    roll_start = 1'b0;
    w = 0;
    while (!face_req && w < 50) begin w++; @(negedge clk); end
    chk("rst_mid first_req", int'(face_req), 1);
    face_ack = 1'b1; face_value = 5'd4;
    @(negedge clk);
    face_ack = 1'b0;
    w = 0;
    while (!face_req && w < 50) begin w++; @(negedge clk); end
    chk("rst_mid second_req", int'(face_req), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid face_req", int'(face_req), 0);
    chk("rst_mid total", int'(total), 0);
    chk("rst_mid tumble", int'(tumble), 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_mid no_pulse", pulses - p0, 0);
    chk("rst_mid stays_idle", int'(busy), 0);
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
